// File: rtl/dmem_dump_arbiter.sv
// dmem_dump_arbiter
// Owns the single data-memory port. The CPU MEM stage uses it until the
// program finishes; after that a small sequencer reads every word in turn
// and streams {addr, data} beats over a valid/ready channel. dump_done
// rises once the last beat has been accepted and stays high until reset.
module dmem_dump_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 512
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              finish,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_busy,
    output logic              dump_done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_CAPT  = 3'd2,
        S_OUT   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Address of the last word to dump; the pointer stops here and never wraps.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_r;
    logic [ADDR_W-1:0] ptr_r;

    // RAM read data goes straight back to the CPU; it is only meaningful
    // the cycle after a granted read.
    assign cpu_rdata = mem_rdata;

    // Port ownership: CPU in IDLE/DONE, sequencer in ISSUE/CAPT/OUT.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        cpu_stall = 1'b0;
        case (state_r)
            S_IDLE, S_DONE: begin
                mem_en = cpu_req;
                mem_we = cpu_req & cpu_we;
            end
            S_ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = 1'b0;
                mem_addr  = ptr_r;
                cpu_stall = cpu_req;
            end
            S_CAPT, S_OUT: begin
                // Port is held by the sequencer even while idle so a CPU
                // write can never slip into the RAM mid-dump.
                mem_addr  = ptr_r;
                cpu_stall = cpu_req;
            end
            default: begin
                mem_en    = 1'b0;
                mem_we    = 1'b0;
                cpu_stall = cpu_req;
            end
        endcase
    end

    // Dump sequencer: walks ptr from 0 to LAST_ADDR, one beat per handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            ptr_r      <= '0;
            dump_valid <= 1'b0;
            dump_addr  <= '0;
            dump_data  <= '0;
            dump_busy  <= 1'b0;
            dump_done  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (finish) begin
                        ptr_r     <= '0;
                        dump_busy <= 1'b1;
                        state_r   <= S_ISSUE;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    // Read for ptr is on the port this cycle; data lands next cycle.
                    state_r <= S_CAPT;
                end
                S_CAPT: begin
                    dump_data  <= mem_rdata;
                    dump_addr  <= ptr_r;
                    dump_valid <= 1'b1;
                    state_r    <= S_OUT;
                end
                S_OUT: begin
                    if (dump_ready) begin
                        dump_valid <= 1'b0;
                        if (ptr_r == LAST_ADDR) begin
                            dump_busy <= 1'b0;
                            dump_done <= 1'b1;
                            state_r   <= S_DONE;
                        end else begin
                            ptr_r   <= ptr_r + ADDR_W'(1);
                            state_r <= S_ISSUE;
                        end
                    end else begin
                        state_r <= S_OUT;
                    end
                end
                S_DONE: begin
                    // Terminal until reset; finish is ignored here.
                    state_r <= S_DONE;
                end
                default: begin
                    state_r    <= S_IDLE;
                    dump_valid <= 1'b0;
                    dump_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_dump_arbiter.sv
// Self-checking bench for dmem_dump_arbiter: table of CPU-port vectors plus
// hand-written dump sequences (timing, back-pressure, CPU blocking,
// finish/write collision, mid-dump reset, finish in DONE).
module tb_dmem_dump_arbiter;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 512;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;
    logic              finish;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              dump_valid;
    logic              dump_ready;
    logic [ADDR_W-1:0] dump_addr;
    logic [DATA_W-1:0] dump_data;
    logic              dump_busy;
    logic              dump_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] ram     [DEPTH];
    logic [DATA_W-1:0] exp_mem [DEPTH];

    dmem_dump_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .finish(finish),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr),
        .dump_data(dump_data), .dump_busy(dump_busy), .dump_done(dump_done)
    );

    always #5 clk = ~clk;

    // Registered-read single-port RAM model.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dump_valid"}, 64'(dump_valid), 64'd0);
        check({tag, "_dump_addr"},  64'(dump_addr),  64'd0);
        check({tag, "_dump_data"},  64'(dump_data),  64'd0);
        check({tag, "_dump_busy"},  64'(dump_busy),  64'd0);
        check({tag, "_dump_done"},  64'(dump_done),  64'd0);
        check({tag, "_mem_en"},     64'(mem_en),     64'd0);
        check({tag, "_mem_we"},     64'(mem_we),     64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; finish = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; dump_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Fill RAM with 3*i through the CPU port while in IDLE.
    task automatic preload();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            cpu_req = 1'b1; cpu_we = 1'b1;
            cpu_addr = ADDR_W'(i); cpu_wdata = 32'(3 * i);
            exp_mem[i] = 32'(3 * i);
        end
        @(negedge clk);
        cpu_req = 1'b0; cpu_we = 1'b0;
    endtask

    // Raise finish for one edge (E0); optionally collide with a CPU write of 0x1234 to addr 0.
    task automatic start_dump(input bit e0_write);
        @(negedge clk);
        finish = 1'b1;
        if (e0_write) begin
            cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'd0; cpu_wdata = 32'h0000_1234;
            exp_mem[0] = 32'h0000_1234;
        end
        @(posedge clk);
    endtask

    // Cycle-by-cycle dump collector. cyc counts edges since E0; samples at negedge+1.
    task automatic run_dump(input int hold_addr, input int hold_len, input bit poke, input int abort_beat);
        int cyc = 0, beats = 0, order_err = 0, hold_err = 0, held = 0;
        int stall_err = 0, busy_err = 0, first_valid = -1, done_cyc = -1;
        bit aborted = 1'b0;
        while (done_cyc < 0 && !aborted && cyc < 5000) begin
            @(negedge clk);
            if (cyc == 0) begin
                finish = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
            end
            if (poke) begin
                if (cyc >= 1 && cyc <= 6) begin
                    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'd3; cpu_wdata = 32'hFFFF_FFFF;
                end else begin
                    cpu_req = 1'b0; cpu_we = 1'b0;
                end
            end
            #1;
            if (poke && cyc >= 1 && cyc <= 6 && (cpu_stall !== 1'b1 || mem_we !== 1'b0))
                stall_err++;
            if (dump_valid && first_valid < 0) first_valid = cyc;
            if (dump_done) begin
                done_cyc = cyc;
            end else begin
                if (dump_busy !== 1'b1) busy_err++;
                if (abort_beat >= 0 && dump_valid && int'(dump_addr) == abort_beat) begin
                    rst_n = 1'b0;
                    #1;
                    aborted = 1'b1;
                    check_reset_outputs("abort");
                end else begin
                    if (dump_valid && int'(dump_addr) == hold_addr && held < hold_len) begin
                        dump_ready = 1'b0;
                        held++;
                        if (dump_addr !== ADDR_W'(hold_addr) || dump_data !== exp_mem[hold_addr])
                            hold_err++;
                    end else begin
                        dump_ready = 1'b1;
                    end
                    if (dump_valid && dump_ready) begin
                        if (beats >= DEPTH || dump_addr !== ADDR_W'(beats) || dump_data !== exp_mem[beats])
                            order_err++;
                        beats++;
                    end
                    @(posedge clk);
                    cyc++;
                end
            end
        end
        check("dump_complete", 64'(done_cyc >= 0 || aborted), 64'd1);
        check("beat_order_errors", 64'(order_err), 64'd0);
        check("busy_during_dump_errors", 64'(busy_err), 64'd0);
        check("first_valid_cycle", 64'(first_valid), 64'd2);
        if (aborted) begin
            check("beats_before_abort", 64'(beats), 64'(abort_beat));
        end else begin
            check("beat_count", 64'(beats), 64'(DEPTH));
            check("done_cycle", 64'(done_cyc), 64'(3 * DEPTH + hold_len));
            check("busy_after_done", 64'(dump_busy), 64'd0);
            check("valid_after_done", 64'(dump_valid), 64'd0);
        end
        if (hold_len > 0) begin
            check("hold_cycles", 64'(held), 64'(hold_len));
            check("hold_stability_errors", 64'(hold_err), 64'd0);
        end
        if (poke) check("cpu_blocked_errors", 64'(stall_err), 64'd0);
        dump_ready = 1'b0;
    endtask

    typedef struct {
        logic              req;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              exp_en;
        logic              exp_we;
        logic              chk_rd;
        logic [DATA_W-1:0] exp_rd;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int seen_valid;
        int seen_busy;
        rst_n = 1'b0; finish = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; dump_ready = 1'b0;

        vecs[0] = '{1'b1, 1'b1, 9'd5,   32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 9'd5,   32'h0000_0000, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF};
        vecs[2] = '{1'b0, 1'b1, 9'd5,   32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 9'd5,   32'h0000_0000, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF};
        vecs[4] = '{1'b1, 1'b1, 9'd511, 32'hA5A5_A5A5, 1'b1, 1'b1, 1'b0, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 9'd511, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 32'hA5A5_A5A5};

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        check("reset_cpu_stall", 64'(cpu_stall), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // CPU pass-through in IDLE.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cpu_req = vecs[i].req; cpu_we = vecs[i].we;
            cpu_addr = vecs[i].addr; cpu_wdata = vecs[i].wdata;
            #1;
            check($sformatf("vec%0d_mem_en", i), 64'(mem_en), 64'(vecs[i].exp_en));
            check($sformatf("vec%0d_mem_we", i), 64'(mem_we), 64'(vecs[i].exp_we));
            check($sformatf("vec%0d_cpu_stall", i), 64'(cpu_stall), 64'd0);
            if (vecs[i].req) begin
                check($sformatf("vec%0d_mem_addr", i), 64'(mem_addr), 64'(vecs[i].addr));
                check($sformatf("vec%0d_mem_wdata", i), 64'(mem_wdata), 64'(vecs[i].wdata));
            end
            @(posedge clk);
            #1;
            if (vecs[i].chk_rd)
                check($sformatf("vec%0d_cpu_rdata", i), 64'(cpu_rdata), 64'(vecs[i].exp_rd));
        end
        @(negedge clk);
        cpu_req = 1'b0; cpu_we = 1'b0;

        // Full dump, sink always ready.
        preload();
        start_dump(1'b0);
        run_dump(-1, 0, 1'b0, -1);
        check("runA_dump_done", 64'(dump_done), 64'd1);

        // Back-pressure on beat 7, blocked CPU write to addr 3, write colliding with finish.
        do_reset();
        preload();
        start_dump(1'b1);
        run_dump(7, 10, 1'b1, -1);
        check("runB_addr3_kept", 64'(exp_mem[3]), 64'd9);

        // Reset at beat 100, then restart from address 0.
        do_reset();
        preload();
        start_dump(1'b0);
        run_dump(-1, 0, 1'b0, 100);
        @(negedge clk);
        rst_n = 1'b1;
        start_dump(1'b0);
        run_dump(-1, 0, 1'b0, -1);

        // finish in DONE: no new beats, CPU owns the port again.
        seen_valid = 0;
        seen_busy  = 0;
        @(negedge clk);
        finish = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'd42;
        #1;
        check("done_cpu_stall", 64'(cpu_stall), 64'd0);
        check("done_mem_en", 64'(mem_en), 64'd1);
        check("done_mem_addr", 64'(mem_addr), 64'd42);
        @(posedge clk);
        #1;
        check("done_cpu_rdata", 64'(cpu_rdata), 64'd126);
        @(negedge clk);
        finish = 1'b0; cpu_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dump_valid) seen_valid++;
            if (dump_busy)  seen_busy++;
        end
        check("done_no_new_valid", 64'(seen_valid), 64'd0);
        check("done_no_busy", 64'(seen_busy), 64'd0);
        check("done_sticky", 64'(dump_done), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
